// File: rtl/crc_pkg.sv
// Shared types, constants and helpers for the reflected CRC-32 stream engine.
package crc_pkg;

  typedef logic [31:0] crc_t;

  localparam crc_t CRC32_INIT      = 32'hFFFF_FFFF;
  localparam crc_t CRC32_RESIDUE   = 32'hDEBB_20E3;
  localparam crc_t CRC32_POLY_REFL = 32'hEDB8_8320;
  localparam int   MAX_LANES       = 16;

  typedef enum logic {
    ST_IDLE,
    ST_ACTIVE
  } frame_state_e;

  // Number of bytes a beat carries: highest set keep bit + 1, or 0 when empty.
  function automatic logic [4:0] keep_count(input logic [MAX_LANES-1:0] keep);
    logic [4:0] cnt;
    cnt = '0;
    for (int i = 0; i < MAX_LANES; i++) begin
      if (keep[i]) cnt = 5'(i + 1);
    end
    return cnt;
  endfunction

  // True when the set keep bits form one run starting at lane 0.
  function automatic logic keep_contiguous(input logic [MAX_LANES-1:0] keep);
    return (keep & (keep + 16'd1)) == '0;
  endfunction

  // Slicing table k: byte b followed by k zero bytes, from a zero register.
  function automatic crc_t crc_table_entry(input int k, input int b);
    crc_t c;
    c = crc_t'(b);
    for (int j = 0; j < 8 * (k + 1); j++) begin
      c = c[0] ? ((c >> 1) ^ CRC32_POLY_REFL) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/crc_slice_step.sv
// Combinational slicing-by-N CRC-32 step over the first n lanes of a beat.
// The lookup tables are constants built at elaboration from the polynomial.
module crc_slice_step
  import crc_pkg::*;
#(
  parameter int SLICE_LENGTH = 8,
  parameter int CNT_W        = $clog2(SLICE_LENGTH + 1)
) (
  input  crc_t                      crc_i,
  input  logic [8*SLICE_LENGTH-1:0] data_i,
  input  logic [CNT_W-1:0]          n_i,
  output crc_t                      crc_next_o
);

  localparam int KW = (SLICE_LENGTH > 1) ? $clog2(SLICE_LENGTH) : 1;

  crc_t tbl [SLICE_LENGTH][256];

  for (genvar k = 0; k < SLICE_LENGTH; k++) begin : g_tbl
    for (genvar b = 0; b < 256; b++) begin : g_ent
      localparam crc_t ENTRY = crc_table_entry(k, b);
      assign tbl[k][b] = ENTRY;
    end
  end

  crc_t          acc;
  logic [7:0]    crc_byte;
  logic [7:0]    idx;
  logic [KW-1:0] k_sel;

  // Lane i sits n-1-i bytes before the last valid byte; only lanes 0..3 mix in the register.
  always_comb begin
    // NOTE: every variable gets a value before any branch so no latch is inferred.
    crc_byte = '0;
    idx      = '0;
    k_sel    = '0;
    acc      = crc_i >> (8 * n_i);
    for (int i = 0; i < SLICE_LENGTH; i++) begin
      if (i < int'(n_i)) begin
        crc_byte = 8'(crc_i >> (8 * i));
        idx      = data_i[8*i +: 8] ^ crc_byte;
        k_sel    = KW'(int'(n_i) - 1 - i);
        acc      = acc ^ tbl[k_sel][idx];
      end
    end
  end

  assign crc_next_o = acc;

endmodule

// File: rtl/crc_stream_engine.sv
// Frame-aware CRC-32 engine: hashes a byte-lane stream and returns one
// registered result per frame through a ready/valid port with backpressure.
module crc_stream_engine
  import crc_pkg::*;
#(
  parameter int   SLICE_LENGTH  = 8,
  parameter crc_t INITIAL_CRC   = CRC32_INIT,
  parameter bit   INVERT_OUTPUT = 1'b1,
  parameter crc_t CHECK_RESIDUE = CRC32_RESIDUE,
  parameter int   LEN_WIDTH     = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [8*SLICE_LENGTH-1:0] s_data,
  input  logic [SLICE_LENGTH-1:0]   s_keep,
  input  logic                      s_valid,
  input  logic                      s_last,
  output logic                      s_ready,
  output logic [31:0]               m_crc,
  output logic [LEN_WIDTH-1:0]      m_len,
  output logic                      m_crc_ok,
  output logic                      m_err,
  output logic                      m_valid,
  input  logic                      m_ready
);

  localparam int CNT_W = $clog2(SLICE_LENGTH + 1);
  localparam int SUM_W = LEN_WIDTH + 1;

  frame_state_e         state_q, state_d;
  crc_t                 crc_q, crc_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic                 err_q, err_d;
  crc_t                 m_crc_q, m_crc_d;
  logic [LEN_WIDTH-1:0] m_len_q, m_len_d;
  logic                 m_ok_q, m_ok_d;
  logic                 m_err_q, m_err_d;
  logic                 m_valid_q, m_valid_d;

  logic [MAX_LANES-1:0] keep_ext;
  logic [CNT_W-1:0]     n;
  logic [SUM_W-1:0]     len_sum;
  logic [LEN_WIDTH-1:0] len_sat;
  logic                 beat_err;
  logic                 accept;
  crc_t                 crc_next;

  assign keep_ext = MAX_LANES'(s_keep);
  assign n        = CNT_W'(keep_count(keep_ext));
  assign beat_err = !keep_contiguous(keep_ext);
  assign s_ready  = !m_valid_q || m_ready;
  assign accept   = s_valid && s_ready;
  assign len_sum  = {1'b0, len_q} + SUM_W'(n);
  assign len_sat  = len_sum[LEN_WIDTH] ? '1 : len_sum[LEN_WIDTH-1:0];

  crc_slice_step #(
    .SLICE_LENGTH(SLICE_LENGTH),
    .CNT_W       (CNT_W)
  ) u_step (
    .crc_i     (crc_q),
    .data_i    (s_data),
    .n_i       (n),
    .crc_next_o(crc_next)
  );

  // Frame state is observational; the datapath does not depend on it.
  always_comb begin
    state_d = state_q;
    if (accept) state_d = s_last ? ST_IDLE : ST_ACTIVE;
  end

  always_comb begin
    crc_d     = crc_q;
    len_d     = len_q;
    err_d     = err_q;
    m_crc_d   = m_crc_q;
    m_len_d   = m_len_q;
    m_ok_d    = m_ok_q;
    m_err_d   = m_err_q;
    m_valid_d = m_valid_q && !m_ready;
    if (accept) begin
      if (s_last) begin
        // A publish on the same edge as a consume simply overwrites the result.
        m_crc_d   = INVERT_OUTPUT ? ~crc_next : crc_next;
        m_len_d   = len_sat;
        m_ok_d    = (crc_next == CHECK_RESIDUE);
        m_err_d   = err_q || beat_err;
        m_valid_d = 1'b1;
        crc_d     = INITIAL_CRC;
        len_d     = '0;
        err_d     = 1'b0;
      end else begin
        crc_d = crc_next;
        len_d = len_sat;
        err_d = err_q || beat_err;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      crc_q     <= INITIAL_CRC;
      len_q     <= '0;
      err_q     <= 1'b0;
      m_crc_q   <= '0;
      m_len_q   <= '0;
      m_ok_q    <= 1'b0;
      m_err_q   <= 1'b0;
      m_valid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q   <= state_d;
      crc_q     <= crc_d;
      len_q     <= len_d;
      err_q     <= err_d;
      m_crc_q   <= m_crc_d;
      m_len_q   <= m_len_d;
      m_ok_q    <= m_ok_d;
      m_err_q   <= m_err_d;
      m_valid_q <= m_valid_d;
    end
  end

  assign m_crc    = m_crc_q;
  assign m_len    = m_len_q;
  assign m_crc_ok = m_ok_q;
  assign m_err    = m_err_q;
  assign m_valid  = m_valid_q;

endmodule

// File: tb/tb_crc_stream_engine.sv
// Directed bench for crc_stream_engine: table of known CRC-32 frames plus
// hand-written backpressure, back-to-back, reset and edge-frame sequences.
module tb_crc_stream_engine;

  localparam int SL = 8;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [8*SL-1:0] s_data;
  logic [SL-1:0] s_keep;
  logic          s_valid;
  logic          s_last;
  logic          s_ready;
  logic [31:0]   m_crc;
  logic [LW-1:0] m_len;
  logic          m_crc_ok;
  logic          m_err;
  logic          m_valid;
  logic          m_ready;

  int n_checks = 0;
  int n_errors = 0;

  typedef logic [7:0] byte_q_t[$];

  typedef struct {
    string       msg;
    int          bpb;
    bit          add_fcs;
    logic [31:0] fcs;
    logic [31:0] exp_crc;
    int          exp_len;
    bit          exp_ok;
  } vec_t;

  vec_t vecs [10];

  crc_stream_engine #(
    .SLICE_LENGTH (SL),
    .LEN_WIDTH    (LW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .s_data   (s_data),
    .s_keep   (s_keep),
    .s_valid  (s_valid),
    .s_last   (s_last),
    .s_ready  (s_ready),
    .m_crc    (m_crc),
    .m_len    (m_len),
    .m_crc_ok (m_crc_ok),
    .m_err    (m_err),
    .m_valid  (m_valid),
    .m_ready  (m_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_result(input string name, input logic [31:0] crc, input int len,
                              input bit ok, input bit err);
    check($sformatf("%s m_valid", name), 64'(m_valid), 64'(1));
    check($sformatf("%s m_crc", name), 64'(m_crc), 64'(crc));
    check($sformatf("%s m_len", name), 64'(m_len), 64'(len));
    check($sformatf("%s m_crc_ok", name), 64'(m_crc_ok), 64'(ok));
    check($sformatf("%s m_err", name), 64'(m_err), 64'(err));
  endtask

  task automatic check_reset_outputs(input string name);
    check($sformatf("%s s_ready", name), 64'(s_ready), 64'(1));
    check($sformatf("%s m_valid", name), 64'(m_valid), 64'(0));
    check($sformatf("%s m_crc", name), 64'(m_crc), 64'(0));
    check($sformatf("%s m_len", name), 64'(m_len), 64'(0));
    check($sformatf("%s m_crc_ok", name), 64'(m_crc_ok), 64'(0));
    check($sformatf("%s m_err", name), 64'(m_err), 64'(0));
  endtask

  // Presents one beat and holds it until accepted; returns #1 after the accepting edge.
  task automatic drive_beat(input logic [8*SL-1:0] d, input logic [SL-1:0] k, input bit last);
    int guard;
    guard   = 0;
    s_data  = d;
    s_keep  = k;
    s_last  = last;
    s_valid = 1'b1;
    while (!s_ready && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!s_ready) begin
      n_checks++;
      n_errors++;
      $display("FAIL beat_accept: s_ready stuck at 0 after %0d cycles, required 1", guard);
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  function automatic byte_q_t str_bytes(input string s);
    byte_q_t q;
    q = {};
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    return q;
  endfunction

  task automatic send_frame(input byte_q_t bytes, input int bpb);
    int idx;
    int cnt;
    logic [8*SL-1:0] d;
    logic [SL-1:0]   k;
    idx = 0;
    do begin
      d   = '0;
      k   = '0;
      cnt = (bytes.size() - idx < bpb) ? bytes.size() - idx : bpb;
      for (int i = 0; i < cnt; i++) begin
        d[8*i +: 8] = bytes[idx + i];
        k[i]        = 1'b1;
      end
      idx += cnt;
      drive_beat(d, k, idx >= bytes.size());
    end while (idx < bytes.size());
  endtask

  initial begin
    byte_q_t bq;
    logic [31:0] held_crc;

    vecs[0] = '{"123456789", 8, 1'b0, 32'h0, 32'hCBF43926, 9, 1'b0};
    vecs[1] = '{"123456789", 1, 1'b0, 32'h0, 32'hCBF43926, 9, 1'b0};
    vecs[2] = '{"123456789", 3, 1'b0, 32'h0, 32'hCBF43926, 9, 1'b0};
    vecs[3] = '{"a", 8, 1'b0, 32'h0, 32'hE8B7BE43, 1, 1'b0};
    vecs[4] = '{"abc", 2, 1'b0, 32'h0, 32'h352441C2, 3, 1'b0};
    vecs[5] = '{"hello world", 5, 1'b0, 32'h0, 32'h0D4A1185, 11, 1'b0};
    vecs[6] = '{"The quick brown fox jumps over the lazy dog", 8, 1'b0, 32'h0,
                32'h414FA339, 43, 1'b0};
    vecs[7] = '{"123456789", 8, 1'b1, 32'hCBF43926, 32'h2144DF1C, 13, 1'b1};
    vecs[8] = '{"123456789", 4, 1'b1, 32'hCBF43926, 32'h2144DF1C, 13, 1'b1};
    vecs[9] = '{"123", 7, 1'b0, 32'h0, 32'h884863D2, 3, 1'b0};

    reset   = 1'b1;
    s_data  = '0;
    s_keep  = '0;
    s_valid = 1'b0;
    s_last  = 1'b0;
    m_ready = 1'b1;
    #1;
    check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // Table-driven frames, consumer always ready.
    for (int v = 0; v < 10; v++) begin
      bq = str_bytes(vecs[v].msg);
      if (vecs[v].add_fcs) begin
        for (int b = 0; b < 4; b++) bq.push_back(vecs[v].fcs[8*b +: 8]);
      end
      send_frame(bq, vecs[v].bpb);
      check_result($sformatf("vec%0d", v), vecs[v].exp_crc, vecs[v].exp_len,
                   vecs[v].exp_ok, 1'b0);
    end
    @(posedge clk); #1;
    check("idle m_valid cleared", 64'(m_valid), 64'(0));

    // Backpressure: result held for 5 cycles while a junk beat is offered.
    m_ready = 1'b0;
    send_frame(str_bytes("abc"), 8);
    check_result("bp first", 32'h352441C2, 3, 1'b0, 1'b0);
    held_crc = m_crc;
    s_data   = 64'hDEAD_BEEF_0BAD_F00D;
    s_keep   = 8'hFF;
    s_last   = 1'b1;
    s_valid  = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check($sformatf("bp s_ready c%0d", c), 64'(s_ready), 64'(0));
      check($sformatf("bp m_valid c%0d", c), 64'(m_valid), 64'(1));
      check($sformatf("bp m_crc c%0d", c), 64'(m_crc), 64'(held_crc));
      check($sformatf("bp m_len c%0d", c), 64'(m_len), 64'(3));
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    m_ready = 1'b1;
    #1;
    check("bp s_ready release", 64'(s_ready), 64'(1));
    send_frame(str_bytes("123456789"), 8);
    check_result("bp second", 32'hCBF43926, 9, 1'b0, 1'b0);

    // Back-to-back single-beat frames: one fresh result every cycle.
    drive_beat(64'h61, 8'h01, 1'b1);
    check_result("b2b a", 32'hE8B7BE43, 1, 1'b0, 1'b0);
    drive_beat(64'h636261, 8'h07, 1'b1);
    check_result("b2b abc", 32'h352441C2, 3, 1'b0, 1'b0);
    drive_beat(64'h333231, 8'h07, 1'b1);
    check_result("b2b 123", 32'h884863D2, 3, 1'b0, 1'b0);
    drive_beat(64'h00, 8'h01, 1'b1);
    check_result("b2b zero byte", 32'hD202EF8D, 1, 1'b0, 1'b0);
    @(posedge clk); #1;
    check("b2b drained", 64'(m_valid), 64'(0));

    // Reset discards a pending result.
    m_ready = 1'b0;
    send_frame(str_bytes("a"), 8);
    check("pending before reset", 64'(m_valid), 64'(1));
    reset = 1'b1;
    #1;
    check_reset_outputs("reset pending");
    @(posedge clk); #1;
    reset   = 1'b0;
    m_ready = 1'b1;
    @(posedge clk); #1;

    // Reset mid-frame after three beats, then a clean frame.
    for (int b = 0; b < 3; b++) drive_beat(64'h1122_3344_5566_7788 + 64'(b), 8'hFF, 1'b0);
    reset = 1'b1;
    #1;
    check_reset_outputs("reset midframe");
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    send_frame(str_bytes("123456789"), 8);
    check_result("after reset", 32'hCBF43926, 9, 1'b0, 1'b0);

    // Empty frame: lone zero-keep beat with s_last.
    drive_beat(64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 1'b1);
    check_result("empty frame", 32'h00000000, 0, 1'b0, 1'b0);

    // Zero-keep beat inside a frame changes nothing.
    drive_beat(64'h34333231, 8'h0F, 1'b0);
    drive_beat(64'hAAAA_AAAA_AAAA_AAAA, 8'h00, 1'b0);
    drive_beat(64'h39_38_37_36_35, 8'h1F, 1'b1);
    check_result("zero beat midframe", 32'hCBF43926, 9, 1'b0, 1'b0);

    // Hole in keep: lane 1 still hashed, error flagged.
    drive_beat(64'h333231, 8'h05, 1'b1);
    check_result("keep hole", 32'h884863D2, 3, 1'b0, 1'b1);

    // Keep error is per-frame: the next clean frame reports no error.
    send_frame(str_bytes("abc"), 8);
    check_result("err cleared", 32'h352441C2, 3, 1'b0, 1'b0);

    // Length saturation: 8200 full beats = 65600 bytes.
    for (int b = 0; b < 8200; b++) drive_beat(64'(b), 8'hFF, b == 8199);
    check("saturate m_valid", 64'(m_valid), 64'(1));
    check("saturate m_len", 64'(m_len), 64'(16'hFFFF));
    check("saturate m_err", 64'(m_err), 64'(0));

    @(posedge clk); #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
